// File: rtl/display_frame_sequencer.sv
// Frame sequencer for the garbled-display datapath: latch msg/z, gather rnd beats, capture pixels, stream rows.
// Optional DISPLAY_FRAME_CNT_EN adds a 16-bit wrapping frame counter output (frame_cnt).
module display_frame_sequencer #(
    parameter int unsigned WIDTH    = 120,
    parameter int unsigned HEIGHT   = 52,
    parameter int unsigned NB_SEG   = 70,
    parameter int unsigned RNDSIZE  = 16,
    parameter int unsigned RND_BEAT = 8,
    localparam int unsigned IDX_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NB_SEG-1:0]         msg_in,
    input  logic                      z_in,
    output logic                      busy,
    input  logic [RND_BEAT-1:0]       rnd_data,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    output logic [NB_SEG-1:0]         dp_msg,
    output logic                      dp_z,
    output logic [RNDSIZE-1:0]        dp_rnd,
    input  logic [WIDTH*HEIGHT-1:0]   dp_pix,
    output logic [WIDTH-1:0]          row_data,
    output logic [IDX_W-1:0]          row_idx,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic                      frame_done
`ifdef DISPLAY_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam int unsigned NBEATS = (RND_BEAT > 0) ? RNDSIZE / RND_BEAT : 1;
    localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    if (RND_BEAT == 0 || (RNDSIZE % RND_BEAT) != 0) begin : g_bad_beat
        $error("RNDSIZE must be a non-zero multiple of RND_BEAT");
    end

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CAPTURE, S_STREAM, S_DONE} state_t;

    state_t                     state_q;
    logic [BW-1:0]              beat_q;
    logic [NB_SEG-1:0]          msg_q;
    logic                       z_q;
    logic [RNDSIZE-1:0]         rnd_q;
    logic [WIDTH*HEIGHT-1:0]    pix_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       busy_q;
    logic                       rnd_ready_q;
    logic                       row_valid_q;
    logic                       frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            msg_q        <= '0;
            z_q          <= 1'b0;
            rnd_q        <= '0;
            pix_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            rnd_ready_q  <= 1'b0;
            row_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        msg_q       <= msg_in;
                        z_q         <= z_in;
                        beat_q      <= '0;
                        busy_q      <= 1'b1;
                        rnd_ready_q <= 1'b1;
                        state_q     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (rnd_valid && rnd_ready_q) begin
                        rnd_q[beat_q*RND_BEAT +: RND_BEAT] <= rnd_data;
                        // ready drops with the last beat so no surplus beat is ever taken
                        if (beat_q == BW'(NBEATS - 1)) begin
                            rnd_ready_q <= 1'b0;
                            state_q     <= S_CAPTURE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_CAPTURE: begin
                    pix_q       <= dp_pix;
                    row_valid_q <= 1'b1;
                    state_q     <= S_STREAM;
                end
                S_STREAM: begin
                    if (row_ready) begin
                        if (idx_q == IDX_W'(HEIGHT - 1)) begin
                            idx_q        <= '0;
                            row_valid_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    rnd_q        <= '0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        row_data = pix_q[idx_q*WIDTH +: WIDTH];
    end

    assign busy       = busy_q;
    assign rnd_ready  = rnd_ready_q;
    assign dp_msg     = msg_q;
    assign dp_z       = z_q;
    assign dp_rnd     = rnd_q;
    assign row_idx    = idx_q;
    assign row_valid  = row_valid_q;
    assign frame_done = frame_done_q;

`ifdef DISPLAY_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Scoreboard bench for display_frame_sequencer with a small pixel datapath stub.
module tb_display_frame_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned NS = 8;
    localparam int unsigned RS = 8;
    localparam int unsigned RB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NS-1:0]   msg_in;
    logic            z_in;
    logic            busy;
    logic [RB-1:0]   rnd_data;
    logic            rnd_valid;
    logic            rnd_ready;
    logic [NS-1:0]   dp_msg;
    logic            dp_z;
    logic [RS-1:0]   dp_rnd;
    logic [W*H-1:0]  dp_pix;
    logic [W-1:0]    row_data;
    logic [1:0]      row_idx;
    logic            row_valid;
    logic            row_ready;
    logic            frame_done;
`ifdef DISPLAY_FRAME_CNT_EN
    logic [15:0]     frame_cnt;
`endif

    display_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .NB_SEG(NS), .RNDSIZE(RS), .RND_BEAT(RB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .msg_in(msg_in), .z_in(z_in),
        .busy(busy), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .dp_msg(dp_msg), .dp_z(dp_z), .dp_rnd(dp_rnd), .dp_pix(dp_pix),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .row_ready(row_ready), .frame_done(frame_done)
`ifdef DISPLAY_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    assign dp_pix = {dp_rnd[3:0], dp_rnd[7:4], dp_rnd[3:0]} ^ {12{dp_z}};

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rows_acc  = 0;
    int fd_count  = 0;
    logic [5:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted row is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && row_valid && row_ready) begin
            rows_acc++;
            if (exp_q.size() == 0) begin
                chk("row_unexpected", {26'd0, row_idx, row_data}, 32'hFFFF_FFFF);
            end else begin
                chk("row", {26'd0, row_idx, row_data}, {26'd0, exp_q.pop_front()});
            end
        end
        if (!rst && frame_done) fd_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rows(input logic [7:0] rnd, input logic z);
        logic [3:0] nib;
        for (int i = 0; i < 3; i++) begin
            nib = (i == 1) ? rnd[7:4] : rnd[3:0];
            exp_q.push_back({2'(i), nib ^ {4{z}}});
        end
    endtask

    task automatic do_start(input logic z, input logic [7:0] msg);
        start  = 1'b1;
        z_in   = z;
        msg_in = msg;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done && n < 50) begin
            tick();
            n++;
        end
        chk(name, frame_done, 1);
    endtask

    task automatic run_frame(input logic z, input logic [7:0] msg, input logic [3:0] b0, input logic [3:0] b1);
        push_rows({b1, b0}, z);
        do_start(z, msg);
        chk("fill_busy", busy, 1);
        chk("fill_rnd_ready", rnd_ready, 1);
        chk("fill_dp_msg", dp_msg, msg);
        chk("fill_dp_z", dp_z, z);
        rnd_valid = 1'b1; rnd_data = b0; tick();
        rnd_data = b1; tick();
        rnd_valid = 1'b0;
        chk("cap_rnd_ready", rnd_ready, 0);
        chk("cap_dp_rnd", dp_rnd, {b1, b0});
        chk("cap_row_valid", row_valid, 0);
        tick();
        chk("latency_row_valid", row_valid, 1);
        wait_done("frame_done_seen");
        tick();
        chk("post_busy", busy, 0);
        chk("post_dp_rnd", dp_rnd, 0);
        chk("post_frame_done", frame_done, 0);
        chk("post_rows_drained", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rnd_ready"}, rnd_ready, 0);
        chk({tag, "_row_valid"}, row_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_row_idx"}, row_idx, 0);
        chk({tag, "_dp_msg"}, dp_msg, 0);
        chk({tag, "_dp_z"}, dp_z, 0);
        chk({tag, "_dp_rnd"}, dp_rnd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd0;
        int acc0;
        rst = 1'b1; start = 1'b0; msg_in = '0; z_in = 1'b0;
        rnd_data = '0; rnd_valid = 1'b0; row_ready = 1'b1;
        tick(); tick();
        chk_reset_vals("rst");
`ifdef DISPLAY_FRAME_CNT_EN
        chk("rst_frame_cnt", frame_cnt, 0);
`endif
        rst = 1'b0;
        tick();

        // Basic frame
        run_frame(1'b0, 8'h3C, 4'hA, 4'h5);

        // Backpressure on row 1
        fd0 = fd_count; acc0 = rows_acc;
        push_rows(8'h5A, 1'b0);
        do_start(1'b0, 8'h5A);
        rnd_valid = 1'b1; rnd_data = 4'hA; tick();
        rnd_data = 4'h5; tick();
        rnd_valid = 1'b0;
        tick();
        tick();
        row_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_row_idx", row_idx, 1);
            chk("bp_row_data", row_data, 4'h5);
            chk("bp_row_valid", row_valid, 1);
        end
        row_ready = 1'b1;
        wait_done("bp_frame_done");
        tick();
        chk("bp_rows_accepted", rows_acc - acc0, 3);
        chk("bp_done_pulses", fd_count - fd0, 1);

        // Random-stream stall, z=1, surplus beat offered
        push_rows(8'h96, 1'b1);
        do_start(1'b1, 8'hA5);
        rnd_valid = 1'b1; rnd_data = 4'h6; tick();
        rnd_valid = 1'b0; tick();
        chk("stall_rnd_ready", rnd_ready, 1);
        tick();
        chk("stall_busy", busy, 1);
        rnd_valid = 1'b1; rnd_data = 4'h9; tick();
        rnd_data = 4'hF;
        chk("stall_cap_rnd_ready", rnd_ready, 0);
        chk("stall_cap_dp_rnd", dp_rnd, 8'h96);
        tick();
        chk("stall_stream_rnd_ready", rnd_ready, 0);
        chk("stall_stream_dp_rnd", dp_rnd, 8'h96);
        wait_done("stall_frame_done");
        rnd_valid = 1'b0;
        tick();
        chk("stall_post_busy", busy, 0);
        chk("stall_rows_drained", exp_q.size(), 0);

        // Ignored start in STREAM and in DONE
        push_rows(8'h21, 1'b0);
        do_start(1'b0, 8'h42);
        rnd_valid = 1'b1; rnd_data = 4'h1; tick();
        rnd_data = 4'h2; tick();
        rnd_valid = 1'b0;
        row_ready = 1'b0;
        tick();
        start = 1'b1; msg_in = 8'hFF; z_in = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_dp_msg", dp_msg, 8'h42);
        chk("ign_dp_z", dp_z, 0);
        chk("ign_row_idx", row_idx, 0);
        chk("ign_row_valid", row_valid, 1);
        row_ready = 1'b1;
        wait_done("ign_frame_done");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_done_busy", busy, 0);
        tick();
        chk("ign_idle_busy", busy, 0);
        chk("ign_idle_rnd_ready", rnd_ready, 0);
        chk("ign_idle_dp_msg", dp_msg, 8'h42);

        // Reset mid-frame
        fd0 = fd_count;
        do_start(1'b1, 8'h77);
        rnd_valid = 1'b1; rnd_data = 4'h7; tick();
        rnd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("mid");
        tick();
        chk("mid_no_done", fd_count - fd0, 0);
        run_frame(1'b0, 8'h11, 4'h3, 4'hC);

`ifdef DISPLAY_FRAME_CNT_EN
        chk("cnt_after_one", frame_cnt, 1);
        run_frame(1'b0, 8'h01, 4'h1, 4'h2);
        chk("cnt_after_two", frame_cnt, 2);
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        chk("cnt_forced", frame_cnt, 16'hFFFF);
        run_frame(1'b0, 8'h02, 4'h4, 4'h8);
        chk("cnt_wrap", frame_cnt, 0);
`endif

        chk("final_rows_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
